// File: rtl/adc_sample_fifo_pkg.sv
// Shared constants for the ADC sample capture path.
// Holds the ADC result width, the default FIFO geometry and the default averaging factor.
// Other ADC-side blocks import this package so they all agree on the sample width.
package adc_sample_fifo_pkg;

  localparam int unsigned AdcDataWidth = 12;
  localparam int unsigned DefDepth     = 16;
  localparam int unsigned DefWmLevel   = 8;
  localparam int unsigned DefAvgLog2   = 2;

  // The occupancy counter needs one more bit than the pointers so that it can hold DEPTH itself.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_eoc_sync.sv
// Three-flop synchroniser with rising-edge detector.
// Brings a level from another clock domain into sys_clk and emits a single-cycle pulse
// for every rising edge of that level. Also intended for the busy/irq crossings.
// Ports:
//   sys_clk   - destination clock
//   reset_    - asynchronous active-low reset
//   async_in  - level from the foreign clock domain
//   pulse_out - one sys_clk pulse per rising edge of async_in
module adc_eoc_sync (
  input  logic sys_clk,
  input  logic reset_,
  input  logic async_in,
  output logic pulse_out
);

  // sync_q[0] is the metastability catcher; only sync_q[1] and sync_q[2] are used downstream.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO.
// Captures every completed ADC conversion into a sys_clk flop-array FIFO so firmware can read
// bursts between polls. Provides count/empty/full/watermark status, a sticky overflow flag and
// a synchronous flush. Optional decimating averager enabled by defining SAMPLE_AVG_EN.
// Ports:
//   sys_clk, reset_ - clock and asynchronous active-low reset
//   clr             - synchronous flush of FIFO, overflow and averager
//   adc_eoc         - ADC ack level (adc_clk domain), rising edge marks a new sample
//   adc_data        - ADC result, stable while adc_eoc is high
//   rd_en           - pop request
//   rd_data         - registered popped sample
//   rd_valid        - one-cycle pulse qualifying rd_data
//   count           - occupancy 0..DEPTH
//   empty/full      - count == 0 / count == DEPTH
//   watermark       - count >= WM_LEVEL
//   overflow        - sticky, a sample was dropped while full
module adc_sample_fifo
  import adc_sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AdcDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned WM_LEVEL   = DefWmLevel,
  parameter int unsigned AVG_LOG2   = DefAvgLog2
) (
  input  logic                   sys_clk,
  input  logic                   reset_,
  input  logic                   clr,
  input  logic                   adc_eoc,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   watermark,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic                  push_req;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;

  adc_eoc_sync u_eoc_sync (
    .sys_clk   (sys_clk),
    .reset_    (reset_),
    .async_in  (adc_eoc),
    .pulse_out (push_req)
  );

`ifdef SAMPLE_AVG_EN
  localparam int unsigned AccW = DATA_WIDTH + AVG_LOG2;

  logic [AccW-1:0]     acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;

  // acc_sum includes the current sample, so the last sample of a group lands in the average.
  always_comb begin
    acc_sum   = acc_q + AccW'(adc_data);
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    wr_req    = 1'b0;
    wr_data   = acc_sum[AVG_LOG2 +: DATA_WIDTH];
    if (clr) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end else if (push_req) begin
      if (avg_cnt_q == {AVG_LOG2{1'b1}}) begin
        wr_req    = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  // adc_data is not synchronised: the ADC holds it stable for as long as ack is high,
  // which covers the synchroniser latency.
  assign wr_req  = push_req;
  assign wr_data = adc_data;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wp_q, wp_d;
  logic [PtrW-1:0]       rp_q, rp_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  is_full, is_empty;
  logic                  do_push, do_pop;

  assign is_full  = (count_q == CntW'(DEPTH));
  assign is_empty = (count_q == '0);

  // A pop in the same cycle frees a slot, so a push while full still lands.
  // A pop while empty is ignored even when a push lands in the same cycle.
  assign do_pop  = rd_en & ~is_empty & ~clr;
  assign do_push = wr_req & ~clr & (~is_full | do_pop);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (do_push) begin
        wp_d = wp_q + PtrW'(1);
      end
      if (do_pop) begin
        rp_d       = rp_q + PtrW'(1);
        rd_data_d  = mem_q[rp_q];
        rd_valid_d = 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
      if (wr_req && is_full && !do_pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign watermark = (count_q >= CntW'(WM_LEVEL));
  assign overflow  = ovf_q;

endmodule
